// File: rtl/lfsr_chk.sv
// Galois LFSR sequence checker: hunts, verifies a candidate pair, then tracks the stream.
// Outputs are registered one cycle after the accepting edge; ready drops only while resync is asserted.
module lfsr_chk #(
  parameter logic [31:0] POLY        = 32'h80200003,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [31:0]      I_data,
  input  logic             I_resync,
  output logic             O_locked,
  output logic             O_err,
  output logic [CNT_W-1:0] O_err_cnt,
  output logic [31:0]      O_expected
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

  function automatic logic [31:0] step(input logic [31:0] x);
    step = {x[30:0], x[31]} ^ ((x[31] ? POLY : 32'h0) & 32'hFFFF_FFFE);
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      cand;
  logic [31:0]      expected;
  logic [3:0]       miss;
  logic [CNT_W-1:0] err_cnt;
  logic             err;

  logic             xfer;
  logic             hit_verify;
  logic             hit_locked;
  logic             lose_lock;

  // resync wins over valid, so it also gates the transfer
  assign xfer       = I_valid & ~I_resync;
  assign hit_verify = (I_data == step(cand));
  assign hit_locked = (I_data == expected);
  assign lose_lock  = ((miss + 4'd1) == LOSS_T);

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (I_resync) begin
      state_nxt = HUNT;
    end else if (xfer) begin
      case (state)
        HUNT:    state_nxt = VERIFY;
        VERIFY:  if (hit_verify) state_nxt = LOCKED;
        LOCKED:  if (!hit_locked && lose_lock) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    O_locked   = (state == LOCKED);
    O_ready    = ~I_resync;
    O_err      = err;
    O_err_cnt  = err_cnt;
    O_expected = expected;
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      cand     <= 32'h0;
      expected <= 32'h0;
      miss     <= 4'd0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      err <= 1'b0;
      if (I_resync) begin
        miss    <= 4'd0;
        err_cnt <= '0;
      end else if (xfer) begin
        case (state)
          HUNT: cand <= I_data;
          VERIFY: begin
            if (hit_verify) begin
              expected <= step(I_data);
              miss     <= 4'd0;
            end else begin
              cand <= I_data;
            end
          end
          LOCKED: begin
            // expected advances on bad words too, so one corrupt word costs one error
            expected <= step(expected);
            if (hit_locked) begin
              miss <= 4'd0;
            end else begin
              miss <= miss + 4'd1;
              err  <= 1'b1;
              if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_chk.sv
// Bench for lfsr_chk: vector table, directed corner sequences and a randomized run against a reference model.
module tb_lfsr_chk;

  localparam logic [31:0] POLY = 32'h80200003;
  localparam int          LT   = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        resync = 1'b0;
  logic [31:0] data = 32'h0;
  logic        rdy, locked, err;
  logic [15:0] cnt;
  logic [31:0] expx;

  logic        s_valid = 1'b0;
  logic        s_resync = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        s_rdy, s_locked, s_err;
  logic [3:0]  s_cnt;
  logic [31:0] s_expx;

  lfsr_chk #(.POLY(POLY), .LOSS_THRESH(LT), .CNT_W(16)) dut (
    .I_clk(clk), .I_reset_n(rst_n), .I_valid(valid), .O_ready(rdy), .I_data(data),
    .I_resync(resync), .O_locked(locked), .O_err(err), .O_err_cnt(cnt), .O_expected(expx)
  );

  lfsr_chk #(.POLY(POLY), .LOSS_THRESH(LT), .CNT_W(4)) sdut (
    .I_clk(clk), .I_reset_n(rst_n), .I_valid(s_valid), .O_ready(s_rdy), .I_data(s_data),
    .I_resync(s_resync), .O_locked(s_locked), .O_err(s_err), .O_err_cnt(s_cnt), .O_expected(s_expx)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // multiply-by-x in GF(2)[x] modulo the polynomial, one coefficient at a time
  function automatic logic [31:0] rs(input logic [31:0] x);
    logic [31:0] y;
    y[0] = x[31];
    for (int i = 1; i < 32; i++) y[i] = x[i-1] ^ (POLY[i] & x[31]);
    return y;
  endfunction

  // reference model: lock = two consecutive accepted words forming a step pair;
  // loss = the last LT judged words in lock all wrong
  bit          m_locked;
  logic [31:0] m_exp;
  int          m_cnt;
  bit          m_err;
  logic [31:0] hist[$];
  bit          res[$];

  task automatic model_reset();
    m_locked = 1'b0; m_exp = 32'h0; m_cnt = 0; m_err = 1'b0;
    hist.delete(); res.delete();
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [31:0] d);
    bit all_bad;
    m_err = 1'b0;
    if (r) begin
      m_locked = 1'b0; m_cnt = 0; hist.delete();
    end else if (v) begin
      if (m_locked) begin
        res.push_back(d == m_exp);
        if (d != m_exp) begin
          m_err = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
        m_exp = rs(m_exp);
        all_bad = (res.size() >= LT);
        for (int k = 0; k < LT && k < res.size(); k++)
          if (res[res.size()-1-k]) all_bad = 1'b0;
        if (all_bad) begin
          m_locked = 1'b0; hist.delete();
        end
      end else begin
        hist.push_back(d);
        if (hist.size() > 2) void'(hist.pop_front());
        if (hist.size() == 2 && hist[1] == rs(hist[0])) begin
          m_locked = 1'b1; m_exp = rs(d); res.delete();
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input bit r, input logic [31:0] d);
    @(negedge clk);
    valid = v; resync = r; data = d;
    #1 chk("ready", rdy, !r);
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    chk("locked", locked, m_locked);
    chk("err", err, m_err);
    chk("cnt", cnt, m_cnt);
    if (m_locked) chk("expected", expx, m_exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; resync = 1'b0; data = 32'h0;
    s_valid = 1'b0; s_resync = 1'b0; s_data = 32'h0;
    @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_expected", expx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", rdy, 1);
    model_reset();
  endtask

  task automatic s_send(input logic [31:0] d);
    @(negedge clk);
    s_valid = 1'b1; s_data = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          v;
    bit          r;
    logic [31:0] d;
    bit          rdy;
    bit          lk;
    bit          er;
    int          c;
    bit          cx;
    logic [31:0] x;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] s[0:15];

  function automatic void add(bit v, bit r, logic [31:0] d, bit lk, bit er, int c,
                              bit cx, logic [31:0] x);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.rdy = !r; t.lk = lk; t.er = er; t.c = c; t.cx = cx; t.x = x;
    tbl.push_back(t);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] g;
    logic [31:0] d;
    bit          v, r;
    int          exp_c;

    s[0] = 32'hBED4DEAD;
    for (int i = 1; i < 16; i++) s[i] = rs(s[i-1]);

    // lock, single error, gap, miss-clear, loss, relock, resync, false candidate, zero word
    add(1, 0, 32'hBED4DEAD,     0, 0, 0, 0, 32'h0);
    add(1, 0, 32'hFD89BD59,     1, 0, 0, 1, 32'h7B337AB1);
    add(1, 0, 32'h7B337AB0,     1, 1, 1, 1, s[3]);
    add(0, 0, 32'h0,            1, 0, 1, 1, s[3]);
    add(1, 0, s[3],             1, 0, 1, 1, s[4]);
    add(1, 0, 32'h0,            1, 1, 2, 1, s[5]);
    add(1, 0, 32'h0,            1, 1, 3, 1, s[6]);
    add(1, 0, 32'h0,            1, 1, 4, 1, s[7]);
    add(1, 0, 32'h0,            0, 1, 5, 0, 32'h0);
    add(1, 0, s[10],            0, 0, 5, 0, 32'h0);
    add(1, 0, s[11],            1, 0, 5, 1, s[12]);
    add(1, 1, s[12],            0, 0, 0, 0, 32'h0);
    add(1, 0, 32'h12345678,     0, 0, 0, 0, 32'h0);
    add(1, 0, 32'hBED4DEAD,     0, 0, 0, 0, 32'h0);
    add(1, 0, 32'hFD89BD59,     1, 0, 0, 1, 32'h7B337AB1);
    add(0, 1, 32'h0,            0, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0,            0, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0,            1, 0, 0, 1, 32'h0);
    add(1, 0, 32'h0,            1, 0, 0, 1, 32'h0);
    add(1, 0, 32'h1,            1, 1, 1, 1, 32'h0);

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      valid = tbl[i].v; resync = tbl[i].r; data = tbl[i].d;
      #1 chk($sformatf("vec%0d_ready", i), rdy, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("vec%0d_err", i), err, tbl[i].er);
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].c);
      if (tbl[i].cx) chk($sformatf("vec%0d_expected", i), expx, tbl[i].x);
    end

    // resync with a simultaneous word while locked with three errors
    do_reset();
    cycle(1, 0, s[0]);
    cycle(1, 0, s[1]);
    chk("lock_expected", expx, 32'h7B337AB1);
    cycle(1, 0, 32'h0);
    cycle(1, 0, 32'h0);
    cycle(1, 0, 32'h0);
    chk("three_err_cnt", cnt, 3);
    chk("three_err_locked", locked, 1);
    @(negedge clk);
    valid = 1'b1; resync = 1'b1; data = s[5];
    #1 chk("resync_ready", rdy, 0);
    @(posedge clk);
    model_edge(1'b1, 1'b1, s[5]);
    #1;
    chk("resync_locked", locked, 0);
    chk("resync_cnt", cnt, 0);
    chk("resync_err", err, 0);
    cycle(1, 0, s[6]);
    chk("resync_word_not_consumed", locked, 0);
    cycle(1, 0, s[7]);
    chk("resync_relock", locked, 1);

    // reset for one cycle in mid-lock, with a bad word presented on that edge
    cycle(1, 0, 32'h1);
    chk("pre_reset_err", err, 1);
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b1; resync = 1'b0; data = 32'h1;
    @(posedge clk);
    model_reset();
    #1;
    chk("midlock_rst_locked", locked, 0);
    chk("midlock_rst_err", err, 0);
    chk("midlock_rst_cnt", cnt, 0);
    chk("midlock_rst_expected", expx, 0);
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    #1 chk("midlock_rst_ready", rdy, 1);
    cycle(0, 0, 32'h0);

    // saturation on the 4-bit counter: five lock/lose rounds of four misses
    g = 32'hBED4DEAD;
    for (int rnd = 0; rnd < 5; rnd++) begin
      s_send(g); g = rs(g);
      s_send(g); g = rs(g);
      chk($sformatf("sat_lock%0d", rnd), s_locked, 1);
      for (int k = 0; k < 4; k++) begin
        s_send(g ^ 32'h1);
        g = rs(g);
      end
      exp_c = (4 * (rnd + 1) > 15) ? 15 : 4 * (rnd + 1);
      chk($sformatf("sat_cnt%0d", rnd), s_cnt, exp_c);
      chk($sformatf("sat_loss%0d", rnd), s_locked, 0);
    end
    @(negedge clk);
    s_valid = 1'b0;

    // correct stream with random gaps
    do_reset();
    g = $urandom;
    repeat (300) begin
      v = ($urandom_range(0, 1) == 1);
      cycle(v, 0, g);
      if (v) g = rs(g);
    end
    chk("gap_locked", locked, 1);
    chk("gap_cnt", cnt, 0);

    // random corruption, sequence jumps and resyncs
    repeat (2000) begin
      if ($urandom_range(0, 49) == 0) g = $urandom;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 39) == 0);
      d = g;
      if ($urandom_range(0, 7) == 0) d = g ^ (32'h1 << $urandom_range(0, 31));
      cycle(v, r, d);
      if (v && !r) g = rs(g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
